// File: rtl/irq_ctl_if.sv
// CPU data-bus view of the interrupt controller register block.
// The CPU side drives address/data/strobes; the controller returns the address hit and read data.
interface irq_ctl_if;
  logic [31:0] memAddr;
  logic [31:0] memWriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        sel;
  logic [31:0] rdata;

  modport master (output memAddr, memWriteData, MemRead, MemWrite, input sel, rdata);
  modport slave  (input memAddr, memWriteData, MemRead, MemWrite, output sel, rdata);
endinterface

// File: rtl/irq_ctl.sv
// Interrupt controller for the beta CPU: edge-latched pending bits, mask, fixed priority, EOI handshake.
// Optional macro IRQ_TIMER_EN adds a reloading down-counter as source index NSRC (TLOAD at offset 0x14).
module irq_ctl #(
  parameter int          NSRC      = 8,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  input  logic [31:0]     ia,
  irq_ctl_if.slave        bus,
  output logic            irq
);

`ifdef IRQ_TIMER_EN
  localparam int NW = NSRC + 1;
`else
  localparam int NW = NSRC;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ASSERT = 2'd1, SERVICE = 2'd2} state_t;

  state_t          state, state_nx;
  logic [NW-1:0]   pending, mask, act, set_vec, w1c_clr, eoi_clr;
  logic [NSRC-1:0] src_q, rise;
  logic [3:0]      active_id;
  logic [4:0]      claim_id, eoi_id;
  logic            claim_valid, wr, eoi_wr, ack;
  logic [2:0]      offset;
  logic [31:0]     rdata_c;
  logic            unused_bits;

  assign bus.sel  = (bus.memAddr[31:5] == BASE_ADDR[31:5]);
  assign offset   = bus.memAddr[4:2];
  assign wr       = bus.MemWrite && bus.sel;
  assign eoi_wr   = wr && (offset == 3'd3);
  assign eoi_id   = bus.memWriteData[4:0];
  assign rise     = src & ~src_q;
  assign act      = pending & mask;
  assign irq      = (state == ASSERT);
  assign ack      = irq && !ia[31];

  assign unused_bits = ^{bus.memAddr[1:0], ia[30:0], bus.memWriteData[31:NW], claim_id[4]};

`ifdef IRQ_TIMER_EN
  logic [31:0] tload, tcnt;
  logic        tload_wr, timer_fire;

  assign tload_wr   = wr && (offset == 3'd5);
  assign timer_fire = !tload_wr && (tcnt == 32'd1);
  assign set_vec    = {timer_fire, rise};

  // Reload on the 1->0 step; a zero TLOAD reloads zero and the timer stays idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tload <= '0;
      tcnt  <= '0;
    end else if (tload_wr) begin
      tload <= bus.memWriteData;
      tcnt  <= bus.memWriteData;
    end else if (tcnt == 32'd1) begin
      tcnt <= tload;
    end else if (tcnt != 32'd0) begin
      tcnt <= tcnt - 32'd1;
    end
  end
`else
  assign set_vec = rise;
`endif

  always_comb begin
    claim_valid = 1'b0;
    claim_id    = '0;
    for (int i = NW - 1; i >= 0; i--) begin
      if (act[i]) begin
        claim_valid = 1'b1;
        claim_id    = 5'(i);
      end
    end
  end

  always_comb begin
    w1c_clr = '0;
    eoi_clr = '0;
    for (int i = 0; i < NW; i++) begin
      w1c_clr[i] = wr && (offset == 3'd0) && bus.memWriteData[i];
      eoi_clr[i] = eoi_wr && (eoi_id == 5'(i));
    end
  end

  // A new edge in the same cycle as a software clear keeps the bit pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending   <= '0;
      mask      <= '0;
      src_q     <= '0;
      active_id <= '0;
    end else begin
      src_q   <= src;
      pending <= (pending & ~w1c_clr & ~eoi_clr) | set_vec;
      if (wr && (offset == 3'd1))
        mask <= bus.memWriteData[NW-1:0];
      if ((state == ASSERT) && ack)
        active_id <= claim_id[3:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (claim_valid) state_nx = ASSERT;
      ASSERT:  if (ack) state_nx = SERVICE;
               else if (!claim_valid) state_nx = IDLE;
      SERVICE: if (eoi_wr) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    rdata_c = '0;
    if (bus.sel && bus.MemRead) begin
      case (offset)
        3'd0: rdata_c = 32'(pending);
        3'd1: rdata_c = 32'(mask);
        3'd2: rdata_c = {claim_valid, 26'd0, claim_id};
        3'd4: rdata_c = {26'd0, state, active_id};
`ifdef IRQ_TIMER_EN
        3'd5: rdata_c = tload;
`endif
        default: rdata_c = '0;
      endcase
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_irq_ctl.sv
// Directed self-checking bench for irq_ctl: registers, edge latch, FSM handshake, priority, timer.
`timescale 1ns/1ps
module tb_irq_ctl;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam logic [31:0] USR  = 32'h0000_1000;
  localparam logic [31:0] SUP  = 32'h8000_0040;

  logic       clk, reset;
  logic [7:0] src;
  logic [31:0] ia, d;
  logic       irq;
  int         pass_cnt, chk_cnt;

  irq_ctl_if bus ();

  irq_ctl #(.NSRC(8), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .ia    (ia),
    .bus   (bus.slave),
    .irq   (irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [4:0] off, input logic [31:0] val);
    bus.memAddr      = BASE | 32'(off);
    bus.memWriteData = val;
    bus.MemWrite     = 1'b1;
    step();
    bus.MemWrite     = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] off, output logic [31:0] val);
    bus.memAddr = BASE | 32'(off);
    bus.MemRead = 1'b1;
    #0.2;
    val = bus.rdata;
    bus.MemRead = 1'b0;
  endtask

  task automatic pulse_src(input logic [7:0] v);
    src = v;
    step();
    src = 8'h00;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h0) $display("FAIL reset_pending got=%h exp=%h", d, 32'h0); else pass_cnt++;
    read_reg(5'h04, d); chk_cnt++; if (d !== 32'h0) $display("FAIL reset_mask got=%h exp=%h", d, 32'h0); else pass_cnt++;
    read_reg(5'h08, d); chk_cnt++; if (d !== 32'h0) $display("FAIL reset_claim got=%h exp=%h", d, 32'h0); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h0) $display("FAIL reset_state got=%h exp=%h", d, 32'h0); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL reset_irq got=%b exp=0", irq); else pass_cnt++;
  endtask

  task automatic test_claim();
    write_reg(5'h04, 32'h04);
    pulse_src(8'h04);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h04) $display("FAIL claim_pending got=%h exp=%h", d, 32'h04); else pass_cnt++;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL claim_irq_early got=%b exp=0", irq); else pass_cnt++;
    step();
    chk_cnt++; if (irq !== 1'b1) $display("FAIL claim_irq got=%b exp=1", irq); else pass_cnt++;
    read_reg(5'h08, d); chk_cnt++; if (d !== 32'h8000_0002) $display("FAIL claim_read got=%h exp=%h", d, 32'h8000_0002); else pass_cnt++;
    step();
    chk_cnt++; if (irq !== 1'b0) $display("FAIL ack_irq got=%b exp=0", irq); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h22) $display("FAIL ack_state got=%h exp=%h", d, 32'h22); else pass_cnt++;
  endtask

  task automatic test_eoi();
    write_reg(5'h04, 32'h05);
    pulse_src(8'h01);
    chk_cnt++; if (irq !== 1'b0) $display("FAIL service_irq got=%b exp=0", irq); else pass_cnt++;
    ia = SUP;
    write_reg(5'h0C, 32'h2);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h01) $display("FAIL eoi_pending got=%h exp=%h", d, 32'h01); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h02) $display("FAIL eoi_state got=%h exp=%h", d, 32'h02); else pass_cnt++;
    step();
    chk_cnt++; if (irq !== 1'b1) $display("FAIL eoi_reassert got=%b exp=1", irq); else pass_cnt++;
    read_reg(5'h08, d); chk_cnt++; if (d !== 32'h8000_0000) $display("FAIL eoi_claim got=%h exp=%h", d, 32'h8000_0000); else pass_cnt++;
  endtask

  task automatic test_supervisor();
    for (int i = 0; i < 10; i++) begin
      step();
      chk_cnt++; if (irq !== 1'b1) $display("FAIL sup_irq cycle=%0d got=%b exp=1", i, irq); else pass_cnt++;
    end
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h12) $display("FAIL sup_state got=%h exp=%h", d, 32'h12); else pass_cnt++;
    write_reg(5'h04, 32'h0);
    chk_cnt++; if (irq !== 1'b1) $display("FAIL unmask_irq_hold got=%b exp=1", irq); else pass_cnt++;
    step();
    chk_cnt++; if (irq !== 1'b0) $display("FAIL unmask_irq_drop got=%b exp=0", irq); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h02) $display("FAIL unmask_state got=%h exp=%h", d, 32'h02); else pass_cnt++;
  endtask

  task automatic test_set_wins();
    src = 8'h08;
    write_reg(5'h00, 32'h08);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h09) $display("FAIL setwin_pending got=%h exp=%h", d, 32'h09); else pass_cnt++;
    write_reg(5'h00, 32'h09);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h00) $display("FAIL level_norepend got=%h exp=%h", d, 32'h00); else pass_cnt++;
    src = 8'h00;
    step();
    pulse_src(8'h20);
    write_reg(5'h0C, 32'h5);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h00) $display("FAIL idle_eoi_pending got=%h exp=%h", d, 32'h00); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h02) $display("FAIL idle_eoi_state got=%h exp=%h", d, 32'h02); else pass_cnt++;
  endtask

  task automatic test_priority();
    write_reg(5'h04, 32'hFF);
    pulse_src(8'h60);
    step();
    chk_cnt++; if (irq !== 1'b1) $display("FAIL prio_irq got=%b exp=1", irq); else pass_cnt++;
    read_reg(5'h08, d); chk_cnt++; if (d !== 32'h8000_0005) $display("FAIL prio_claim got=%h exp=%h", d, 32'h8000_0005); else pass_cnt++;
    ia = USR;
    step();
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h25) $display("FAIL prio_service got=%h exp=%h", d, 32'h25); else pass_cnt++;
    ia = SUP;
    write_reg(5'h04, 32'h0);
    write_reg(5'h0C, 32'h5);
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h40) $display("FAIL prio_eoi_pending got=%h exp=%h", d, 32'h40); else pass_cnt++;
    read_reg(5'h10, d); chk_cnt++; if (d !== 32'h05) $display("FAIL prio_eoi_state got=%h exp=%h", d, 32'h05); else pass_cnt++;
    write_reg(5'h00, 32'hFF);
  endtask

  task automatic test_decode();
    read_reg(5'h18, d); chk_cnt++; if (d !== 32'h0) $display("FAIL unmapped_read got=%h exp=0", d); else pass_cnt++;
    write_reg(5'h04, 32'h0F);
    bus.memAddr = 32'h0000_1004;
    bus.MemRead = 1'b1;
    #0.2;
    chk_cnt++; if (bus.sel !== 1'b0 || bus.rdata !== 32'h0) $display("FAIL offbase sel=%b rdata=%h exp sel=0 rdata=0", bus.sel, bus.rdata); else pass_cnt++;
    bus.MemRead = 1'b0;
    bus.memAddr = BASE | 32'h4;
    #0.2;
    chk_cnt++; if (bus.sel !== 1'b1 || bus.rdata !== 32'h0) $display("FAIL noread sel=%b rdata=%h exp sel=1 rdata=0", bus.sel, bus.rdata); else pass_cnt++;
    read_reg(5'h04, d); chk_cnt++; if (d !== 32'h0F) $display("FAIL mask_rw got=%h exp=%h", d, 32'h0F); else pass_cnt++;
    write_reg(5'h04, 32'h0);
  endtask

`ifdef IRQ_TIMER_EN
  task automatic test_timer();
    write_reg(5'h04, 32'h100);
    write_reg(5'h14, 32'd5);
    read_reg(5'h14, d); chk_cnt++; if (d !== 32'd5) $display("FAIL tload_read got=%h exp=%h", d, 32'd5); else pass_cnt++;
    for (int i = 0; i < 4; i++) step();
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h0) $display("FAIL timer_early got=%h exp=0", d); else pass_cnt++;
    step();
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h100) $display("FAIL timer_fire got=%h exp=%h", d, 32'h100); else pass_cnt++;
    read_reg(5'h08, d); chk_cnt++; if (d !== 32'h8000_0008) $display("FAIL timer_claim got=%h exp=%h", d, 32'h8000_0008); else pass_cnt++;
    write_reg(5'h00, 32'h100);
    for (int i = 0; i < 3; i++) step();
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h0) $display("FAIL timer_reload_early got=%h exp=0", d); else pass_cnt++;
    step();
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h100) $display("FAIL timer_refire got=%h exp=%h", d, 32'h100); else pass_cnt++;
    write_reg(5'h14, 32'd0);
    write_reg(5'h04, 32'h0);
    write_reg(5'h00, 32'h1FF);
    step(); step();
  endtask
`else
  task automatic test_no_timer();
    read_reg(5'h14, d); chk_cnt++; if (d !== 32'h0) $display("FAIL tload_absent got=%h exp=0", d); else pass_cnt++;
  endtask
`endif

  task automatic test_reset_midop();
    write_reg(5'h04, 32'h04);
    pulse_src(8'h04);
    step();
    chk_cnt++; if (irq !== 1'b1) $display("FAIL midop_irq_pre got=%b exp=1", irq); else pass_cnt++;
    #2 reset = 1'b1;
    #0.2;
    chk_cnt++; if (irq !== 1'b0) $display("FAIL midop_irq got=%b exp=0", irq); else pass_cnt++;
    read_reg(5'h00, d); chk_cnt++; if (d !== 32'h0) $display("FAIL midop_pending got=%h exp=0", d); else pass_cnt++;
    read_reg(5'h04, d); chk_cnt++; if (d !== 32'h0) $display("FAIL midop_mask got=%h exp=0", d); else pass_cnt++;
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    pass_cnt = 0;
    chk_cnt  = 0;
    reset = 1'b0;
    src   = 8'h00;
    ia    = USR;
    bus.memAddr      = 32'h0;
    bus.memWriteData = 32'h0;
    bus.MemRead      = 1'b0;
    bus.MemWrite     = 1'b0;
    test_reset();
    test_claim();
    test_eoi();
    test_supervisor();
    test_set_wins();
    test_priority();
    test_decode();
`ifdef IRQ_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
